// File: rtl/formal_bus_env.sv
// formal_bus_env: shapes per-channel ready/read data around the hart, with a bounded-stall guarantee,
// a sticky request-stability monitor and a saturating completed-transfer counter per channel.
// Latency: rdy_o and rdata_o are combinational. violation_o and txn_cnt_o are registered and update the cycle after the event.
// Backpressure: ready follows rnd_rdy_i but is forced after MAX_STALL stalled cycles. Build with FORMAL_MEM_EN to add a shadow memory.
module formal_bus_env #(
    parameter int          NUM_CH    = 2,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          MAX_STALL = 4,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          MEM_WORDS = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*DATA_W/8-1:0] wmask_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    input  logic [NUM_CH-1:0]        rnd_rdy_i,
    input  logic [NUM_CH*DATA_W-1:0] rnd_data_i,
    output logic [NUM_CH-1:0]        rdy_o,
    output logic [NUM_CH*DATA_W-1:0] rdata_o,
    output logic [NUM_CH-1:0]        violation_o,
    output logic [NUM_CH*16-1:0]     txn_cnt_o
);
    localparam int BYTES = DATA_W / 8;
    // Stall counter must hold 0..MAX_STALL. Keep at least one bit so MAX_STALL = 0 still elaborates.
    localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    // Reject parameter sets the address arithmetic below cannot represent
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("formal_bus_env: DATA_W must be a multiple of 8");
    end
    if (MEM_WORDS < 1 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
        $error("formal_bus_env: MEM_WORDS must be a power of two");
    end
    if (ADDR_W < 64 &&
        (64'(MEM_BASE) + 64'(MEM_WORDS) * 64'(BYTES)) > (64'd1 << ADDR_W)) begin : g_bad_window
        $error("formal_bus_env: shadow-memory window exceeds the address space");
    end

    logic [NUM_CH-1:0] rdy;
    assign rdy_o = rdy;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SW-1:0]     stall_q, stall_d;
        logic              pending_q, pending_d;
        logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
        logic [BYTES-1:0]  lat_wmask_q, lat_wmask_d;
        logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
        logic              viol_q, viol_d;
        logic [15:0]       txn_q, txn_d;

        logic [ADDR_W-1:0] addr_c;
        logic [BYTES-1:0]  wmask_c;
        logic [DATA_W-1:0] wdata_c;
        assign addr_c  = addr_i[c*ADDR_W +: ADDR_W];
        assign wmask_c = wmask_i[c*BYTES +: BYTES];
        assign wdata_c = wdata_i[c*DATA_W +: DATA_W];

        // Ready is the random candidate, forced once the stall budget is used up; never without a request.
        assign rdy[c] = !reset && req_i[c] && (rnd_rdy_i[c] || stall_q == STALL_MAX);

        // Next-state: stall counting, request latching, violation detection and transfer counting.
        always_comb begin
            stall_d     = '0;
            pending_d   = 1'b0;
            lat_addr_d  = lat_addr_q;
            lat_wmask_d = lat_wmask_q;
            lat_wdata_d = lat_wdata_q;
            viol_d      = viol_q;
            txn_d       = txn_q;
            // A stalled request must be held unchanged into the next cycle.
            if (pending_q && (!req_i[c] || addr_c != lat_addr_q ||
                              wmask_c != lat_wmask_q || wdata_c != lat_wdata_q)) begin
                viol_d = 1'b1;
            end
            if (req_i[c] && !rdy[c]) begin
                stall_d     = stall_q + 1'b1;
                pending_d   = 1'b1;
                lat_addr_d  = addr_c;
                lat_wmask_d = wmask_c;
                lat_wdata_d = wdata_c;
            end
            if (req_i[c] && rdy[c] && txn_q != 16'hFFFF) begin
                txn_d = txn_q + 16'd1;
            end
        end

        // Per-channel state registers with synchronous reset.
        always_ff @(posedge clock) begin
            if (reset) begin
                stall_q     <= '0;
                pending_q   <= 1'b0;
                lat_addr_q  <= '0;
                lat_wmask_q <= '0;
                lat_wdata_q <= '0;
                viol_q      <= 1'b0;
                txn_q       <= '0;
            end else begin
                stall_q     <= stall_d;
                pending_q   <= pending_d;
                lat_addr_q  <= lat_addr_d;
                lat_wmask_q <= lat_wmask_d;
                lat_wdata_q <= lat_wdata_d;
                viol_q      <= viol_d;
                txn_q       <= txn_d;
            end
        end

        assign violation_o[c]        = viol_q;
        assign txn_cnt_o[c*16 +: 16] = txn_q;
    end

`ifdef FORMAL_MEM_EN
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int SH    = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(MEM_BASE);
    // One extra bit so a window that reaches the top of the address space still compares correctly.
    localparam logic [ADDR_W:0]   WIN_A  = (ADDR_W + 1)'(MEM_WORDS * BYTES);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic [NUM_CH-1:0] in_win;
    logic [NUM_CH-1:0] wr_en;
    logic [IDX_W-1:0]  widx [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_mem_dec
        logic [ADDR_W-1:0] off;
        assign off       = addr_i[c*ADDR_W +: ADDR_W] - BASE_A;
        assign in_win[c] = (addr_i[c*ADDR_W +: ADDR_W] >= BASE_A) && ({1'b0, off} < WIN_A);
        assign widx[c]   = IDX_W'(off >> SH);
        assign wr_en[c]  = rdy[c] && in_win[c] && (|wmask_i[c*BYTES +: BYTES]);
        // Memory reads see the pre-edge contents, so a same-cycle write is not forwarded.
        assign rdata_o[c*DATA_W +: DATA_W] = in_win[c] ? mem_q[widx[c]]
                                                       : rnd_data_i[c*DATA_W +: DATA_W];
    end

    // Shadow-memory byte writes; later (higher-index) channels overwrite earlier ones per byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wr_en[c] && wmask_i[c*BYTES + b]) begin
                        mem_q[widx[c]][b*8 +: 8] <= wdata_i[c*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end
`else
    assign rdata_o = rnd_data_i;
`endif

endmodule
